// File: rtl/spu_sm_seq_if.sv
// Bus between the softmax sequencer and its lbuf / multi-lane datapath partners.
interface spu_sm_seq_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  sm_lbuf_ren;
  logic [ADDR_WIDTH-1:0] sm_lbuf_raddr;
  logic [DATA_WIDTH-1:0] sm_lbuf_rdata;
  logic                  sm_lbuf_wen;
  logic [ADDR_WIDTH-1:0] sm_lbuf_waddr;
  logic [DATA_WIDTH-1:0] sm_lbuf_wdata;
  logic [1:0]            dp_pass;
  logic                  dp_first;
  logic                  dp_valid;
  logic [DATA_WIDTH-1:0] dp_data;
  logic [LANES-1:0]      dp_mask;
  logic                  dp_reci_start;
  logic                  dp_reci_done;
  logic [DATA_WIDTH-1:0] dp_wdata;

  modport master (
    output sm_lbuf_ren, sm_lbuf_raddr, sm_lbuf_wen, sm_lbuf_waddr, sm_lbuf_wdata,
    output dp_pass, dp_first, dp_valid, dp_data, dp_mask, dp_reci_start,
    input  sm_lbuf_rdata, dp_reci_done, dp_wdata
  );

  modport slave (
    input  sm_lbuf_ren, sm_lbuf_raddr, sm_lbuf_wen, sm_lbuf_waddr, sm_lbuf_wdata,
    input  dp_pass, dp_first, dp_valid, dp_data, dp_mask, dp_reci_start,
    output sm_lbuf_rdata, dp_reci_done, dp_wdata
  );
endinterface

// File: rtl/spu_sm_seq.sv
// Row-wise softmax sequencer: generates lbuf addresses and walks each row through
// the MAX, EXP_A, RECI and EXP_B passes of an external multi-lane datapath.
module spu_sm_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RLATENCY   = 1,
  parameter int EXP_LAT    = 3,
  parameter int MUL_LAT    = 1
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  sm_start,
  input  logic                  sm_abort,
  output logic                  sm_busy,
  output logic                  sm_end,
  output logic                  sm_cfg_err,
  input  logic [ADDR_WIDTH-1:0] spu_matrix_y,
  input  logic [ADDR_WIDTH-1:0] spu_matrix_x,
  input  logic [ADDR_WIDTH-1:0] im_base_addr,
  input  logic [ADDR_WIDTH-1:0] om_base_addr,
  input  logic [ADDR_WIDTH-1:0] ifm_addr_align,
  input  logic [ADDR_WIDTH-1:0] ofm_addr_align,
  spu_sm_seq_if.master          bus
);
  localparam int CW = ADDR_WIDTH + 2;
  localparam int LG = $clog2(LANES);
  localparam logic [ADDR_WIDTH-1:0] LMASK = ADDR_WIDTH'(LANES - 1);
  localparam logic [CW-1:0] RL  = CW'(RLATENCY);
  localparam logic [CW-1:0] EL  = CW'(EXP_LAT);
  localparam logic [CW-1:0] ML  = CW'(MUL_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAX  = 3'd1;
  localparam logic [2:0] S_EXPA = 3'd2;
  localparam logic [2:0] S_RECI = 3'd3;
  localparam logic [2:0] S_EXPB = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] x_q, y_q, ia_q, oa_q, row, im_row, om_row;
  logic                  reci_start;
  logic [ADDR_WIDTH-1:0] rem, words;
  logic [CW-1:0]         wc, wr_lat, pass_last, beat, wr_idx;
  logic                  rd_pass, wr_pass, cfg_bad;
  logic                  ren, dvld, wen;

  function automatic logic [LANES-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] n);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (ADDR_WIDTH'(i) < n);
    return m;
  endfunction

  assign cfg_bad = (spu_matrix_x == '0) || (spu_matrix_y == '0);
  assign rem     = x_q & LMASK;
  assign words   = (x_q >> LG) + ADDR_WIDTH'(rem != '0);
  assign wc      = {2'b00, words};
  assign rd_pass = (state == S_MAX) || (state == S_EXPA) || (state == S_EXPB);
  assign wr_pass = (state == S_EXPA) || (state == S_EXPB);
  assign wr_lat  = (state == S_EXPA) ? EL : ML;
  assign beat    = cnt - RL;
  assign wr_idx  = cnt - RL - wr_lat;

  // Every pass is timed by one cycle counter; read, datapath and write windows
  // are fixed offsets from state entry.
  assign ren  = rd_pass && (cnt < wc);
  assign dvld = rd_pass && (cnt >= RL) && (cnt < wc + RL);
  assign wen  = wr_pass && (cnt >= RL + wr_lat) && (cnt < wc + RL + wr_lat);

  always_comb begin
    case (state)
      S_MAX:   pass_last = wc + RL - ONE;
      S_EXPA:  pass_last = wc + RL + EL - ONE;
      S_EXPB:  pass_last = wc + RL + ML - ONE;
      default: pass_last = '0;
    endcase
  end

  always_comb begin
    bus.sm_lbuf_ren   = ren;
    bus.sm_lbuf_raddr = '0;
    if (ren) bus.sm_lbuf_raddr = ((state == S_EXPB) ? om_row : im_row) + ADDR_WIDTH'(cnt);
    bus.dp_valid      = dvld;
    bus.dp_first      = dvld && (cnt == RL);
    bus.dp_mask       = '0;
    if (dvld) bus.dp_mask = ((beat == wc - ONE) && (rem != '0)) ? lane_mask(rem) : '1;
    bus.sm_lbuf_wen   = wen;
    bus.sm_lbuf_waddr = '0;
    if (wen) bus.sm_lbuf_waddr = om_row + ADDR_WIDTH'(wr_idx);
    case (state)
      S_EXPA:  bus.dp_pass = 2'd1;
      S_RECI:  bus.dp_pass = 2'd2;
      S_EXPB:  bus.dp_pass = 2'd3;
      default: bus.dp_pass = 2'd0;
    endcase
  end

  assign bus.dp_reci_start = reci_start;
  assign bus.dp_data       = bus.sm_lbuf_rdata;
  assign bus.sm_lbuf_wdata = bus.dp_wdata;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ia_q       <= '0;
      oa_q       <= '0;
      row        <= '0;
      im_row     <= '0;
      om_row     <= '0;
      sm_busy    <= 1'b0;
      sm_end     <= 1'b0;
      sm_cfg_err <= 1'b0;
      reci_start <= 1'b0;
    end else begin
      sm_end     <= 1'b0;
      reci_start <= 1'b0;
      if (sm_abort && (state != S_IDLE)) begin
        state   <= S_IDLE;
        cnt     <= '0;
        sm_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sm_start && !sm_abort) begin
              x_q        <= spu_matrix_x;
              y_q        <= spu_matrix_y;
              ia_q       <= ifm_addr_align;
              oa_q       <= ofm_addr_align;
              im_row     <= im_base_addr;
              om_row     <= om_base_addr;
              row        <= '0;
              cnt        <= '0;
              sm_busy    <= 1'b1;
              sm_cfg_err <= cfg_bad;
              state      <= cfg_bad ? S_ERR : S_MAX;
            end
          end
          S_ERR: begin
            state   <= S_IDLE;
            sm_busy <= 1'b0;
            sm_end  <= 1'b1;
          end
          S_MAX: begin
            if (cnt == pass_last) begin
              state <= S_EXPA;
              cnt   <= '0;
            end else cnt <= cnt + ONE;
          end
          S_EXPA: begin
            if (cnt == pass_last) begin
              state      <= S_RECI;
              cnt        <= '0;
              reci_start <= 1'b1;
            end else cnt <= cnt + ONE;
          end
          S_RECI: begin
            if (bus.dp_reci_done) begin
              state <= S_EXPB;
              cnt   <= '0;
            end
          end
          S_EXPB: begin
            if (cnt == pass_last) begin
              cnt <= '0;
              if (row == y_q - ADDR_WIDTH'(1)) begin
                state   <= S_IDLE;
                sm_busy <= 1'b0;
                sm_end  <= 1'b1;
              end else begin
                row    <= row + ADDR_WIDTH'(1);
                im_row <= im_row + ia_q;
                om_row <= om_row + oa_q;
                state  <= S_MAX;
              end
            end else cnt <= cnt + ONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
